ps2_keys: RTL and testbench

PS/2 keyboard front end that supplies the debug page's `keys[4:0]` input. It filters and synchronizes the raw PS/2 clock/data lines, deserializes 11-bit device-to-host frames, and decodes make/break sequences. The result is a held pressed-state mask for five keys plus a raw scan-code strobe. It sits between the board PS/2 pins and the VGA page logic, all in the system clock domain.

---
 rtl/ps2_pkg.sv | 49 ++++
 rtl/ps2_keys_if.sv | 22 ++
 rtl/ps2_rx.sv | 126 ++++++++++++
 rtl/ps2_keys.sv | 72 +++++++
 tb/tb_ps2_keys.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard front end.
// The key table maps five make codes onto bits of the pressed-state mask.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int NUM_KEYS = 5;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [2:0] KEY_W     = 3'd0;
  localparam logic [2:0] KEY_A     = 3'd1;
  localparam logic [2:0] KEY_S     = 3'd2;
  localparam logic [2:0] KEY_D     = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_map_t;

  function automatic key_map_t key_lookup(input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = KEY_W;
    case (code)
      SC_W:     m.idx = KEY_W;
      SC_A:     m.idx = KEY_A;
      SC_S:     m.idx = KEY_S;
      SC_D:     m.idx = KEY_D;
      SC_SPACE: m.idx = KEY_SPACE;
      default:  m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_keys_if.sv
// Pin-side and result-side signals of the PS/2 keyboard front end.
// master drives the PS/2 pins and consumes results; slave is the receiver block.
interface ps2_keys_if import ps2_pkg::*; ();

  logic                ps2_clk;
  logic                ps2_data;
  logic [NUM_KEYS-1:0] keys;
  logic [7:0]          scan_code;
  logic                scan_valid;
  logic                frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keys, scan_code, scan_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keys, scan_code, scan_valid, frame_err
  );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin sync, clock glitch filter, 11-bit frame FSM
// with mid-frame timeout. rx_valid/rx_err are single-cycle combinational strobes.
module ps2_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic                  clk_p0, clk_p1;
  logic                  data_p0, data_p1;
  logic [FILTER_LEN-1:0] filt_sr_p2;
  logic                  filt_clk_p2;
  logic                  sample;

  rx_state_e         state, state_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  // Stage p0/p1: two-flop synchronizers; idle-high so reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= ps2_clk;
      clk_p1  <= clk_p0;
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
    end
  end

  // Stage p2: level changes only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_sr_p2  <= '1;
      filt_clk_p2 <= 1'b1;
    end else begin
      filt_sr_p2 <= {filt_sr_p2[FILTER_LEN-2:0], clk_p1};
      if (&filt_sr_p2)
        filt_clk_p2 <= 1'b1;
      else if (~|filt_sr_p2)
        filt_clk_p2 <= 1'b0;
    end
  end

  // Falling edge seen in the cycle the filter is all-zero but the level is still high
  assign sample = filt_clk_p2 & ~|filt_sr_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = (state == IDLE) ? '0 : tmo_q + 1'b1;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
    if (sample) begin
      tmo_d = '0;
      case (state)
        IDLE: begin
          if (!data_p1) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
        DATA: begin
          shift_d   = {data_p1, shift_q[7:1]};
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7)
            state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_p1;
          state_d = STOP;
        end
        STOP: begin
          if (data_p1 && (^{shift_q, par_q}))
            rx_valid = 1'b1;
          else
            rx_err = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state != IDLE && tmo_q == TMO_LAST) begin
      // Abandoned frame: drop the partial byte and resync on the next start bit
      state_d = IDLE;
      shift_d = '0;
      tmo_d   = '0;
      rx_err  = 1'b1;
    end
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_keys.sv
// PS/2 keyboard front end: receiver plus make/break decoder producing a held
// five-key pressed mask and a raw scan-code strobe for the debug page.
module ps2_keys import ps2_pkg::*; #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  ps2_keys_if.slave   bus
);

  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic                rx_err;
  key_map_t            hit;

  logic [NUM_KEYS-1:0] keys_q;
  logic [7:0]          code_q;
  logic                vld_q;
  logic                err_q;
  logic                brk_q;
  logic                ext_q;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  assign hit = key_lookup(rx_byte);

  // Decode stage: prefixes arm flags; any other byte consumes and clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q <= '0;
      code_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
    end else begin
      vld_q <= rx_valid;
      err_q <= rx_err;
      if (rx_valid) begin
        code_q <= rx_byte;
        if (rx_byte == SC_BREAK) begin
          brk_q <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext_q <= 1'b1;
        end else begin
          if (!ext_q && hit.hit)
            keys_q[hit.idx] <= ~brk_q;
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end
      end
    end
  end

  assign bus.keys       = keys_q;
  assign bus.scan_code  = code_q;
  assign bus.scan_valid = vld_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_ps2_keys.sv
// Scoreboard bench for ps2_keys: frames are bit-banged on the PS/2 pins, the
// expected outcome of each is queued and compared when the block reports it.
module tb_ps2_keys;

  localparam int FL   = 8;
  localparam int TMO  = 1000;
  localparam int HALF = 40;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic [4:0] keys;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_keys_if bus();

  ps2_keys #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;

  logic [4:0] keys_m;
  logic       brk_m;
  logic       ext_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    e.keys   = keys_m;
    sb.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (b == 8'hF0) begin
      brk_m = 1'b1;
    end else if (b == 8'hE0) begin
      ext_m = 1'b1;
    end else begin
      if (!ext_m) begin
        case (b)
          8'h1D: keys_m[0] = ~brk_m;
          8'h1C: keys_m[1] = ~brk_m;
          8'h1B: keys_m[2] = ~brk_m;
          8'h23: keys_m[3] = ~brk_m;
          8'h29: keys_m[4] = ~brk_m;
          default: ;
        endcase
      end
      brk_m = 1'b0;
      ext_m = 1'b0;
    end
    e.is_err = 1'b0;
    e.code   = b;
    e.keys   = keys_m;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    bus.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
    if (glitch) begin
      repeat (10) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
  endtask

  // bad: 0 good frame, 1 parity flipped, 2 stop bit low
  task automatic send_frame(input logic [7:0] code, input int bad, input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {(bad != 2), (~^code) ^ (bad == 1), code, 1'b0};
    if (nbits == 11) begin
      if (bad != 0) push_err();
      else          model_byte(code);
    end
    for (int i = 0; i < nbits; i++)
      drive_bit(f[i], i == glitch_at);
    bus.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && sb.size() != 0; i++)
      @(negedge clk);
    check({tag, "_pending"}, sb.size(), 0);
    check({tag, "_keys_hold"}, bus.keys, keys_m);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (bus.scan_valid || bus.frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {bus.scan_valid, bus.frame_err}, 0);
      end else begin
        e = sb.pop_front();
        check("scan_valid", bus.scan_valid, !e.is_err);
        check("frame_err", bus.frame_err, e.is_err);
        check("keys", bus.keys, e.keys);
        if (!e.is_err)
          check("scan_code", bus.scan_code, e.code);
      end
    end
  end

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    keys_m = '0;
    brk_m  = 1'b0;
    ext_m  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_keys", bus.keys, 0);
    check("rst_scan_code", bus.scan_code, 0);
    check("rst_scan_valid", bus.scan_valid, 0);
    check("rst_frame_err", bus.frame_err, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'h1D, 0, 11, -1);
    drain("single_make");
    check("single_make_mask", bus.keys, 5'b00001);

    send_frame(8'hF0, 0, 11, -1);
    send_frame(8'h1D, 0, 11, -1);
    drain("make_break");
    check("make_break_mask", bus.keys, 5'b00000);

    send_frame(8'h29, 0, 11, -1);
    send_frame(8'h23, 0, 11, -1);
    send_frame(8'hE0, 0, 11, -1);
    send_frame(8'h1D, 0, 11, -1);
    drain("overlap_ext");
    check("overlap_ext_mask", bus.keys, 5'b11000);

    send_frame(8'h1C, 1, 11, -1);
    drain("parity_err");
    check("parity_err_mask", bus.keys, 5'b11000);
    send_frame(8'h1C, 0, 11, -1);
    drain("after_parity");
    check("after_parity_mask", bus.keys, 5'b11010);

    send_frame(8'h55, 2, 11, -1);
    drain("stop_err");

    push_err();
    send_frame(8'h1B, 0, 5, -1);
    repeat (TMO + 200) @(negedge clk);
    drain("timeout");
    send_frame(8'h1B, 0, 11, -1);
    drain("after_timeout");
    check("after_timeout_mask", bus.keys, 5'b11110);

    send_frame(8'hF0, 0, 11, -1);
    send_frame(8'h29, 0, 11, 4);
    drain("glitch");
    check("glitch_mask", bus.keys, 5'b01110);

    send_frame(8'hF0, 0, 11, -1);
    send_frame(8'h1C, 0, 11, -1);
    send_frame(8'hF0, 0, 11, -1);
    send_frame(8'h23, 0, 11, -1);
    send_frame(8'h1D, 0, 11, -1);
    drain("pre_reset");
    check("pre_reset_mask", bus.keys, 5'b00101);

    send_frame(8'h1D, 0, 6, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_keys", bus.keys, 0);
    check("async_rst_scan_code", bus.scan_code, 0);
    check("async_rst_scan_valid", bus.scan_valid, 0);
    check("async_rst_frame_err", bus.frame_err, 0);
    keys_m = '0;
    brk_m  = 1'b0;
    ext_m  = 1'b0;
    sb.delete();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h1B, 0, 11, -1);
    drain("after_reset");
    check("after_reset_mask", bus.keys, 5'b00100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
